alu_ctrl_seq: RTL
=================

# alu_ctrl_seq

Registered, parametrised ALU control unit with multi-cycle operation sequencing. Sits between the main control decoder and the ALU in the datapath. It decodes the 2-bit ALU opcode and the R-type function field into an ALU operation code, and holds multiply and divide operations for a configurable number of cycles. A valid/ready handshake stalls the upstream stage, and illegal R-type function codes are flagged.

## Interface
Parameters:
- FUNCT_W, default 4: function field width. Must be ≥4; only the low 4 bits are decoded, and any upper bit set makes the code illegal.
- OP_W, default 4: operation code width (≥4). Codes are zero-extended.
- MULT_CYCLES, default 4: cycles a multiply is presented to the ALU (≥1).
- DIV_CYCLES, default 8: cycles a divide is presented to the ALU (≥1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream presents alu_op/funct
- in_ready  out  1  block can accept this cycle
- alu_op  in  2  ALU opcode from main control
- funct  in  FUNCT_W  R-type function field
- flush  in  1  synchronous abort of the current operation
- operation  out  OP_W  operation code to the ALU (registered)
- op_valid  out  1  operation is active this cycle
- op_last  out  1  final cycle of the active operation
- busy  out  1  multi-cycle operation in progress, not on its last cycle
- illegal  out  1  active operation came from an undefined funct

## Operation
- Decode, evaluated at accept:
  - alu_op=11 (R-type) decodes funct:
    - 0000 → 0001 add
    - 0010 → 0010 sub
    - 0100 → 0011 mult
    - 0101 → 0100 div
    - 0111 → 0101 move
    - 1000 → 0110 swap
    - 1010 → 0111 and
    - 1011 → 1000 or
  - alu_op=10 → 0001 (load/store address add).
  - alu_op=01 → 1001 (branch compare).
  - alu_op=00 → 0000 (jump/halt).
- Illegal funct under alu_op=11: operation=0000, illegal=1, length 1 cycle.
- Length: mult = MULT_CYCLES, div = DIV_CYCLES, all other codes = 1.
- Internal down-counter cnt, width $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
- Accept = in_valid & in_ready.
- At an accepting edge: operation ← code; op_valid ← 1; illegal ← decode flag; cnt ← length−1.
- Active and cnt≠0 with no flush: cnt decrements each edge; operation and illegal hold.
- Active and cnt=0 with no accept: op_valid ← 0, operation ← 0000, illegal ← 0.
- Derived outputs (combinational from registers and flush):
  - in_ready = !flush & (!op_valid | cnt==0)
  - op_last = op_valid & cnt==0
  - busy = op_valid & cnt≠0
- flush=1: at that edge op_valid ← 0, operation ← 0000, illegal ← 0, cnt ← 0. flush beats accept; in_ready is forced 0, so no input is consumed.
- alu_op/funct are sampled only on accept and ignored otherwise.

## Timing
- Reset (asynchronous, immediate): operation=0000, op_valid=0, illegal=0, cnt=0. Result: in_ready=1, busy=0, op_last=0.
- Reset mid-operation aborts it; nothing resumes after reset deasserts.
- Latency: accept at edge k → op_valid=1 with the code during cycles k+1 … k+L (L = length).
- op_last=1 in cycle k+L only.
- in_ready=1 in cycle k+L, so back-to-back accepts give continuous op_valid with no bubble.
- Single-cycle ops can be accepted every cycle; throughput is 1 op/cycle.
- MULT_CYCLES=1 or DIV_CYCLES=1: that op behaves as single-cycle and busy never asserts for it.
- in_valid held high while in_ready=0 is not an accept. Upstream must hold its inputs until accepted.

## Test plan
- Reset behaviour: reset pulsed asynchronously between edges → outputs immediately 0000/0/0/0, in_ready=1. After release, alu_op=10 accepted → operation=0001 for 1 cycle with op_last=1.
- Full decode table: all 8 legal functs under alu_op=11, plus alu_op=01/00 → codes match the table. Funct 0001 → operation 0000, illegal=1 for 1 cycle.
- Multiply hold (defaults): accept mult at edge k → operation=0011 for cycles k+1..k+4. busy=1 in k+1..k+3; in_ready=0 in k+1..k+3. In k+4: op_last=1, in_ready=1; a queued add is accepted, so 0001 appears in k+5.
- Divide with flush: accept div, assert flush in the 3rd active cycle with in_valid=1 → next cycle op_valid=0, operation=0000, queued input not consumed. in_ready=1 the cycle after flush deasserts.
- Back-to-back single-cycle ops: 6 consecutive ops (sub, and, or, add, move, swap) with in_valid high every cycle → 6 contiguous op_valid cycles, op_last=1 each cycle, busy=0 throughout.
- Parametrisation: FUNCT_W=6, DIV_CYCLES=1, MULT_CYCLES=3. funct=6'b100000 → illegal. Div → 1 cycle with busy never 1. Mult → 3 cycles.

Source files
------------

// File: rtl/alu_ctrl_seq_if.sv
// Handshake and operation bus between the main control decoder, the ALU control
// sequencer and the ALU.
interface alu_ctrl_seq_if #(
  parameter int unsigned FUNCT_W = 4,
  parameter int unsigned OP_W    = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         alu_op;
  logic [FUNCT_W-1:0] funct;
  logic               flush;
  logic [OP_W-1:0]    operation;
  logic               op_valid;
  logic               op_last;
  logic               busy;
  logic               illegal;

  modport master (
    output in_valid, alu_op, funct, flush,
    input  in_ready, operation, op_valid, op_last, busy, illegal
  );

  modport slave (
    input  in_valid, alu_op, funct, flush,
    output in_ready, operation, op_valid, op_last, busy, illegal
  );
endinterface

// File: rtl/alu_ctrl_seq.sv
// ALU control unit: decodes alu_op/funct into an ALU operation code and holds
// multiply/divide codes for a configurable number of cycles behind a valid/ready handshake.
module alu_ctrl_seq #(
  parameter int unsigned FUNCT_W     = 4,
  parameter int unsigned OP_W        = 4,
  parameter int unsigned MULT_CYCLES = 4,
  parameter int unsigned DIV_CYCLES  = 8
) (
  input  logic          clk,
  input  logic          reset,
  alu_ctrl_seq_if.slave bus
);

  localparam int unsigned MAX_LEN = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0]       dec_code;
  logic             dec_ill;
  logic [CNT_W-1:0] dec_last;
  logic             in_ready_c;
  logic             accept;

  // Opcode/function decode; only meaningful on an accepting cycle.
  always_comb begin
    dec_code = 4'b0000;
    dec_ill  = 1'b0;
    dec_last = '0;
    case (bus.alu_op)
      2'b11: begin
        if ((bus.funct >> 4) != '0) begin
          dec_ill = 1'b1;
        end else begin
          case (bus.funct[3:0])
            4'b0000: dec_code = 4'b0001;
            4'b0010: dec_code = 4'b0010;
            4'b0100: begin dec_code = 4'b0011; dec_last = MULT_LAST; end
            4'b0101: begin dec_code = 4'b0100; dec_last = DIV_LAST;  end
            4'b0111: dec_code = 4'b0101;
            4'b1000: dec_code = 4'b0110;
            4'b1010: dec_code = 4'b0111;
            4'b1011: dec_code = 4'b1000;
            default: dec_ill  = 1'b1;
          endcase
        end
      end
      2'b10:   dec_code = 4'b0001;
      2'b01:   dec_code = 4'b1001;
      default: dec_code = 4'b0000;
    endcase
  end

  assign in_ready_c = !bus.flush && ((state_q == S_IDLE) || (cnt_q == '0));
  assign accept     = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush dominates accept; an accept on the last cycle chains without a bubble.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ill_d   = ill_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = S_IDLE;
      op_d    = '0;
      ill_d   = 1'b0;
      cnt_d   = '0;
    end else if (accept) begin
      state_d = S_ACTIVE;
      op_d    = OP_W'(dec_code);
      ill_d   = dec_ill;
      cnt_d   = dec_last;
    end else begin
      case (state_q)
        S_ACTIVE: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            state_d = S_IDLE;
            op_d    = '0;
            ill_d   = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.operation = op_q;
  assign bus.op_valid  = (state_q == S_ACTIVE);
  assign bus.illegal   = ill_q;
  assign bus.op_last   = (state_q == S_ACTIVE) && (cnt_q == '0);
  assign bus.busy      = (state_q == S_ACTIVE) && (cnt_q != '0);

endmodule
